// File: rtl/rv_ctrl_pipe.sv
// Pipelined control and hazard unit for the 5-stage RV32I core: decodes in D,
// carries control through ID/EX, EX/MEM, MEM/WB, resolves branches in E.
module rv_ctrl_pipe #(
    parameter int ALUCTRL_W   = 4,
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    input  logic                 mem_stall,
    output logic [2:0]           imm_src_d,
    output logic [4:0]           rs1_d,
    output logic [4:0]           rs2_d,
    output logic                 illegal_d,
    output logic [ALUCTRL_W-1:0] alu_ctrl_e,
    output logic                 alu_src_a_e,
    output logic                 alu_src_b_e,
    output logic                 jalr_e,
    output logic                 pc_src_e,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 mem_write_m,
    output logic [2:0]           mem_size_m,
    output logic                 reg_write_m,
    output logic [4:0]           rd_m,
    output logic                 reg_write_w,
    output logic [4:0]           rd_w,
    output logic [1:0]           result_src_w
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src_a;
        logic                 alu_src_b;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic [2:0]           funct3;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
    } ctrl_e_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // M has priority over W; a destination of x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic wr_m, input logic [4:0] dst_m,
                                           input logic wr_w, input logic [4:0] dst_w);
        logic [1:0] sel;
        if (wr_m && (dst_m != 5'd0) && (dst_m == rs))      sel = 2'b10;
        else if (wr_w && (dst_w != 5'd0) && (dst_w == rs)) sel = 2'b01;
        else                                               sel = 2'b00;
        return sel;
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    ctrl_e_t    w_dec;
    ctrl_e_t    w_ctrl_d;
    logic       w_legal;
    logic [2:0] w_imm_src;

    assign w_opcode = instr_d[6:0];
    assign w_funct3 = instr_d[14:12];
    assign w_funct7 = instr_d[31:25];

    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b1;
        w_imm_src    = 3'b000;
        w_dec.funct3 = w_funct3;
        w_dec.rd     = instr_d[11:7];
        w_dec.rs1    = instr_d[19:15];
        w_dec.rs2    = instr_d[24:20];
        case (w_opcode)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_ctrl  = ALUCTRL_W'(alu_op(w_funct3, w_funct7[5]));
                // funct7 alternate encoding exists only for sub and sra
                w_legal = (w_funct7 == F7_ZERO) ||
                          ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            OP_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_dec.alu_ctrl  = ALUCTRL_W'(alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]));
                if (w_funct3 == 3'b001)
                    w_legal = (w_funct7 == F7_ZERO);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
            end
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b01;
                w_dec.alu_src_b  = 1'b1;
                w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            end
            OP_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_imm_src       = 3'b001;
                w_legal         = (w_funct3 <= 3'b010);
            end
            OP_BR: begin
                w_dec.branch   = 1'b1;
                w_dec.alu_ctrl = ALUCTRL_W'(ALU_SUB);
                w_imm_src      = 3'b010;
                if (FULL_BRANCH)
                    w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                else
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
                w_imm_src        = 3'b011;
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.alu_src_b  = 1'b1;
                w_legal          = (w_funct3 == 3'b000);
            end
            OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_dec.alu_ctrl  = ALUCTRL_W'(ALU_PASSB);
                w_imm_src       = 3'b100;
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_imm_src       = 3'b100;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // An illegal instruction travels down the pipe as a bubble.
    assign w_ctrl_d  = w_legal ? w_dec : '0;
    assign illegal_d = ~w_legal;
    assign imm_src_d = w_imm_src;
    assign rs1_d     = instr_d[19:15];
    assign rs2_d     = instr_d[24:20];

    ctrl_e_t    r_e;
    logic       r_m_reg_write;
    logic [1:0] r_m_result_src;
    logic       r_m_mem_write;
    logic [2:0] r_m_funct3;
    logic [4:0] r_m_rd;
    logic       r_w_reg_write;
    logic [1:0] r_w_result_src;
    logic [4:0] r_w_rd;

    logic w_taken;
    logic w_pc_src;
    logic w_lw_stall;
    logic w_bubble_e;

    always_comb begin
        case (r_e.funct3)
            3'b000:  w_taken = zero_e;
            3'b001:  w_taken = ~zero_e;
            3'b100:  w_taken = lt_e;
            3'b101:  w_taken = ~lt_e;
            3'b110:  w_taken = ltu_e;
            3'b111:  w_taken = ~ltu_e;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc_src   = r_e.jump | (r_e.branch & w_taken);
    assign w_lw_stall = (r_e.result_src == 2'b01) && (r_e.rd != 5'd0) &&
                        ((r_e.rd == rs1_d) || (r_e.rd == rs2_d));

    // A redirect outranks a load-use stall: the dependent in D is flushed anyway.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        w_bubble_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (w_pc_src) begin
            flush_d    = 1'b1;
            w_bubble_e = 1'b1;
        end else if (w_lw_stall) begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            w_bubble_e = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e            <= '0;
            r_m_reg_write  <= 1'b0;
            r_m_result_src <= 2'b00;
            r_m_mem_write  <= 1'b0;
            r_m_funct3     <= 3'b000;
            r_m_rd         <= 5'd0;
            r_w_reg_write  <= 1'b0;
            r_w_result_src <= 2'b00;
            r_w_rd         <= 5'd0;
        end else if (!mem_stall) begin
            r_e            <= w_bubble_e ? '0 : w_ctrl_d;
            r_m_reg_write  <= r_e.reg_write;
            r_m_result_src <= r_e.result_src;
            r_m_mem_write  <= r_e.mem_write;
            r_m_funct3     <= r_e.funct3;
            r_m_rd         <= r_e.rd;
            r_w_reg_write  <= r_m_reg_write;
            r_w_result_src <= r_m_result_src;
            r_w_rd         <= r_m_rd;
        end
    end

    assign alu_ctrl_e   = r_e.alu_ctrl;
    assign alu_src_a_e  = r_e.alu_src_a;
    assign alu_src_b_e  = r_e.alu_src_b;
    assign jalr_e       = r_e.jalr;
    assign pc_src_e     = w_pc_src;
    assign forward_a_e  = fwd_sel(r_e.rs1, r_m_reg_write, r_m_rd, r_w_reg_write, r_w_rd);
    assign forward_b_e  = fwd_sel(r_e.rs2, r_m_reg_write, r_m_rd, r_w_reg_write, r_w_rd);
    assign mem_write_m  = r_m_mem_write;
    assign mem_size_m   = r_m_funct3;
    assign reg_write_m  = r_m_reg_write;
    assign rd_m         = r_m_rd;
    assign reg_write_w  = r_w_reg_write;
    assign rd_w         = r_w_rd;
    assign result_src_w = r_w_result_src;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Directed bench for rv_ctrl_pipe: reset, load-use, forwarding, branches,
// redirect/freeze interaction and decode coverage, with hand-computed expectations.
module tb_rv_ctrl_pipe;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] ADD_X3   = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] SUB_X4   = 32'h4031_8233; // sub x4,x3,x3
    localparam logic [31:0] ADD_X0   = 32'h0020_8033; // add x0,x1,x2
    localparam logic [31:0] SUB_X4_0 = 32'h4000_0233; // sub x4,x0,x0
    localparam logic [31:0] LW_X5    = 32'h0001_2283; // lw x5,0(x2)
    localparam logic [31:0] ADD_X6   = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] JALR_X1  = 32'h0002_80E7; // jalr x1,0(x5)
    localparam logic [31:0] LUI_X7   = 32'h1234_53B7; // lui x7,0x12345
    localparam logic [31:0] SB_X2    = 32'h0020_8023; // sb x2,0(x1)
    localparam logic [31:0] BAD_OP   = 32'h0000_0380; // opcode 0000000, rd=x7

    logic        clk, rst;
    logic [31:0] instr_d;
    logic        zero_e, lt_e, ltu_e, mem_stall;

    logic [2:0] imm_src_d;
    logic [4:0] rs1_d, rs2_d;
    logic       illegal_d;
    logic [3:0] alu_ctrl_e;
    logic       alu_src_a_e, alu_src_b_e, jalr_e, pc_src_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d;
    logic       mem_write_m;
    logic [2:0] mem_size_m;
    logic       reg_write_m;
    logic [4:0] rd_m;
    logic       reg_write_w;
    logic [4:0] rd_w;
    logic [1:0] result_src_w;

    logic [2:0] nb_imm_src_d;
    logic [4:0] nb_rs1_d, nb_rs2_d;
    logic       nb_illegal_d;
    logic [3:0] nb_alu_ctrl_e;
    logic       nb_alu_src_a_e, nb_alu_src_b_e, nb_jalr_e, nb_pc_src_e;
    logic [1:0] nb_forward_a_e, nb_forward_b_e;
    logic       nb_stall_f, nb_stall_d, nb_flush_d;
    logic       nb_mem_write_m;
    logic [2:0] nb_mem_size_m;
    logic       nb_reg_write_m;
    logic [4:0] nb_rd_m;
    logic       nb_reg_write_w;
    logic [4:0] nb_rd_w;
    logic [1:0] nb_result_src_w;

    int n_checks = 0;
    int n_fail   = 0;

    rv_ctrl_pipe #(.ALUCTRL_W(4), .FULL_BRANCH(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e),
        .ltu_e(ltu_e), .mem_stall(mem_stall), .imm_src_d(imm_src_d), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .illegal_d(illegal_d), .alu_ctrl_e(alu_ctrl_e),
        .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e), .jalr_e(jalr_e),
        .pc_src_e(pc_src_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .mem_write_m(mem_write_m), .mem_size_m(mem_size_m), .reg_write_m(reg_write_m),
        .rd_m(rd_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_src_w(result_src_w)
    );

    rv_ctrl_pipe #(.ALUCTRL_W(4), .FULL_BRANCH(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e),
        .ltu_e(ltu_e), .mem_stall(mem_stall), .imm_src_d(nb_imm_src_d), .rs1_d(nb_rs1_d),
        .rs2_d(nb_rs2_d), .illegal_d(nb_illegal_d), .alu_ctrl_e(nb_alu_ctrl_e),
        .alu_src_a_e(nb_alu_src_a_e), .alu_src_b_e(nb_alu_src_b_e), .jalr_e(nb_jalr_e),
        .pc_src_e(nb_pc_src_e), .forward_a_e(nb_forward_a_e), .forward_b_e(nb_forward_b_e),
        .stall_f(nb_stall_f), .stall_d(nb_stall_d), .flush_d(nb_flush_d),
        .mem_write_m(nb_mem_write_m), .mem_size_m(nb_mem_size_m),
        .reg_write_m(nb_reg_write_m), .rd_m(nb_rd_m), .reg_write_w(nb_reg_write_w),
        .rd_w(nb_rd_w), .result_src_w(nb_result_src_w)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] br_instr [6];
    logic [2:0]  br_taken_flags [6]; // {zero, lt, ltu} that make the branch taken
    logic [31:0] dc_instr [5];
    logic [3:0]  dc_alu [5];
    logic        dc_src_a [5];
    logic        dc_src_b [5];
    logic [2:0]  dc_imm [5];

    initial begin
        br_instr[0] = 32'h0020_8063; br_taken_flags[0] = 3'b100; // beq
        br_instr[1] = 32'h0020_9063; br_taken_flags[1] = 3'b011; // bne
        br_instr[2] = 32'h0020_C063; br_taken_flags[2] = 3'b010; // blt
        br_instr[3] = 32'h0020_D063; br_taken_flags[3] = 3'b101; // bge
        br_instr[4] = 32'h0020_E063; br_taken_flags[4] = 3'b001; // bltu
        br_instr[5] = 32'h0020_F063; br_taken_flags[5] = 3'b110; // bgeu

        dc_instr[0] = 32'h4030_D393; dc_alu[0] = 4'd9;  dc_src_a[0] = 0; dc_src_b[0] = 1; dc_imm[0] = 3'b000; // srai
        dc_instr[1] = 32'h0020_B3B3; dc_alu[1] = 4'd6;  dc_src_a[1] = 0; dc_src_b[1] = 0; dc_imm[1] = 3'b000; // sltu
        dc_instr[2] = 32'h0020_C3B3; dc_alu[2] = 4'd4;  dc_src_a[2] = 0; dc_src_b[2] = 0; dc_imm[2] = 3'b000; // xor
        dc_instr[3] = LUI_X7;        dc_alu[3] = 4'd10; dc_src_a[3] = 0; dc_src_b[3] = 1; dc_imm[3] = 3'b100; // lui
        dc_instr[4] = 32'h0000_1397; dc_alu[4] = 4'd0;  dc_src_a[4] = 1; dc_src_b[4] = 1; dc_imm[4] = 3'b100; // auipc

        rst = 1'b1; instr_d = NOP; zero_e = 0; lt_e = 0; ltu_e = 0; mem_stall = 0;
        cyc(); cyc();
        check("rst_reg_write_w", reg_write_w, 1'b0);
        check("rst_pc_src", pc_src_e, 1'b0);
        check("rst_stall_f", stall_f, 1'b0);
        check("rst_flush_d", flush_d, 1'b0);
        check("rst_fwd_a", forward_a_e, 2'b00);
        check("rst_rd_m", rd_m, 5'd0);

        rst = 1'b0;
        cyc(); cyc(); cyc();

        // asynchronous reset with an add in flight
        instr_d = ADD_X3; cyc();
        instr_d = NOP;    cyc();
        check("pre_rst_rd_m", rd_m, 5'd3);
        #3 rst = 1'b1;
        #1;
        check("async_rst_reg_write_m", reg_write_m, 1'b0);
        check("async_rst_rd_m", rd_m, 5'd0);
        check("async_rst_reg_write_w", reg_write_w, 1'b0);
        check("async_rst_pc_src", pc_src_e, 1'b0);
        cyc();
        rst = 1'b0; instr_d = ADDI_X1;
        cyc(); instr_d = NOP;
        cyc(); #1;
        check("addi_m_rd", rd_m, 5'd1);
        check("addi_w_not_yet", reg_write_w, 1'b0);
        cyc();
        check("addi_w_reg_write", reg_write_w, 1'b1);
        check("addi_w_rd", rd_w, 5'd1);

        // load-use
        instr_d = LW_X5; cyc();
        instr_d = ADD_X6; #1;
        check("lu_stall_f", stall_f, 1'b1);
        check("lu_stall_d", stall_d, 1'b1);
        check("lu_flush_d", flush_d, 1'b0);
        cyc();
        check("lu_after_stall_f", stall_f, 1'b0);
        check("lu_after_stall_d", stall_d, 1'b0);
        check("lu_bubble_fwd_a", forward_a_e, 2'b00);
        check("lu_lw_rd_m", rd_m, 5'd5);
        check("lu_lw_size_m", mem_size_m, 3'b010);
        cyc();
        instr_d = NOP; #1;
        check("lu_fwd_a_w", forward_a_e, 2'b01);
        check("lu_fwd_b_none", forward_b_e, 2'b00);
        check("lu_w_result_src", result_src_w, 2'b01);
        cyc(); cyc();

        // forwarding: back-to-back, one nop apart, M over W, rd=x0
        instr_d = ADD_X3; cyc();
        instr_d = SUB_X4; cyc();
        instr_d = NOP; #1;
        check("fwd_m_a", forward_a_e, 2'b10);
        check("fwd_m_b", forward_b_e, 2'b10);
        cyc(); cyc();
        instr_d = ADD_X3; cyc();
        instr_d = NOP;    cyc();
        instr_d = SUB_X4; cyc();
        instr_d = NOP; #1;
        check("fwd_w_a", forward_a_e, 2'b01);
        check("fwd_w_b", forward_b_e, 2'b01);
        instr_d = ADD_X3; cyc();
        instr_d = ADD_X3; cyc();
        instr_d = SUB_X4; cyc();
        instr_d = NOP; #1;
        check("fwd_prio_a", forward_a_e, 2'b10);
        check("fwd_prio_b", forward_b_e, 2'b10);
        instr_d = ADD_X0;   cyc();
        instr_d = SUB_X4_0; cyc();
        instr_d = NOP; #1;
        check("fwd_x0_a", forward_a_e, 2'b00);
        check("fwd_x0_b", forward_b_e, 2'b00);
        cyc(); cyc();

        // branches: taken / not taken per type, then flush leaves a bubble in E
        for (int i = 0; i < 6; i++) begin
            instr_d = br_instr[i]; #1;
            check($sformatf("br%0d_illegal", i), illegal_d, 1'b0);
            check($sformatf("br%0d_imm_src", i), imm_src_d, 3'b010);
            check($sformatf("br%0d_nb_illegal", i), nb_illegal_d, (i >= 2));
            cyc();
            instr_d = LUI_X7;
            {zero_e, lt_e, ltu_e} = br_taken_flags[i]; #1;
            check($sformatf("br%0d_taken_pc_src", i), pc_src_e, 1'b1);
            check($sformatf("br%0d_taken_flush", i), flush_d, 1'b1);
            check($sformatf("br%0d_taken_stall_d", i), stall_d, 1'b0);
            check($sformatf("br%0d_nb_pc_src", i), nb_pc_src_e, (i < 2));
            {zero_e, lt_e, ltu_e} = ~br_taken_flags[i]; #1;
            check($sformatf("br%0d_not_pc_src", i), pc_src_e, 1'b0);
            check($sformatf("br%0d_not_flush", i), flush_d, 1'b0);
            {zero_e, lt_e, ltu_e} = br_taken_flags[i];
            cyc();
            {zero_e, lt_e, ltu_e} = 3'b000;
            instr_d = NOP; #1;
            check($sformatf("br%0d_bubble_alu", i), alu_ctrl_e, 4'd0);
            check($sformatf("br%0d_bubble_src_b", i), alu_src_b_e, 1'b0);
            cyc();
        end

        // jalr redirect against a load-use dependent in D, then a 3-cycle freeze
        instr_d = ADD_X3;  cyc();
        instr_d = JALR_X1; cyc();
        instr_d = ADD_X6; #1;
        check("col_pc_src", pc_src_e, 1'b1);
        check("col_jalr_e", jalr_e, 1'b1);
        check("col_flush_d", flush_d, 1'b1);
        check("col_stall_d", stall_d, 1'b0);
        check("col_stall_f", stall_f, 1'b0);
        mem_stall = 1'b1; #1;
        check("frz_flush_d", flush_d, 1'b0);
        check("frz_stall_f", stall_f, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("frz%0d_pc_src", k), pc_src_e, 1'b1);
            check($sformatf("frz%0d_jalr_e", k), jalr_e, 1'b1);
            check($sformatf("frz%0d_rd_m", k), rd_m, 5'd3);
            check($sformatf("frz%0d_reg_write_w", k), reg_write_w, 1'b1);
            check($sformatf("frz%0d_rd_w", k), rd_w, 5'd0);
            check($sformatf("frz%0d_stall_d", k), stall_d, 1'b1);
        end
        mem_stall = 1'b0; #1;
        check("unfrz_flush_d", flush_d, 1'b1);
        cyc();
        instr_d = NOP; #1;
        check("unfrz_jalr_e", jalr_e, 1'b0);
        check("unfrz_pc_src", pc_src_e, 1'b0);
        check("unfrz_rd_m", rd_m, 5'd1);
        check("unfrz_rd_w", rd_w, 5'd3);
        cyc(); cyc();

        // decode coverage
        for (int i = 0; i < 5; i++) begin
            instr_d = dc_instr[i]; #1;
            check($sformatf("dc%0d_illegal", i), illegal_d, 1'b0);
            check($sformatf("dc%0d_imm_src", i), imm_src_d, dc_imm[i]);
            if (i == 1) begin
                check("dc_rs1_d", rs1_d, 5'd1);
                check("dc_rs2_d", rs2_d, 5'd2);
            end
            cyc();
            instr_d = NOP; #1;
            check($sformatf("dc%0d_alu_ctrl", i), alu_ctrl_e, dc_alu[i]);
            check($sformatf("dc%0d_src_a", i), alu_src_a_e, dc_src_a[i]);
            check($sformatf("dc%0d_src_b", i), alu_src_b_e, dc_src_b[i]);
        end
        instr_d = SB_X2; #1;
        check("sb_imm_src", imm_src_d, 3'b001);
        cyc();
        instr_d = NOP;
        cyc();
        check("sb_mem_write_m", mem_write_m, 1'b1);
        check("sb_mem_size_m", mem_size_m, 3'b000);
        check("sb_reg_write_m", reg_write_m, 1'b0);

        instr_d = BAD_OP; #1;
        check("bad_illegal", illegal_d, 1'b1);
        cyc();
        instr_d = NOP; #1;
        check("bad_bubble_alu", alu_ctrl_e, 4'd0);
        cyc();
        check("bad_reg_write_m", reg_write_m, 1'b0);
        cyc();
        check("bad_reg_write_w", reg_write_w, 1'b0);
        check("bad_rd_w", rd_w, 5'd0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
